cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache (fetch stage, read-only) and the D-cache (memory-access stage, read/write).
- Sits between the two caches and the cacheline adaptor.
- Sequences one line transaction at a time and forwards the response only to the granted cache.
- D-cache has fixed priority. A starvation counter guarantees I-cache progress.

Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, physical address width
- STARVE_MAX, 8, consecutive lost arbitrations after which the I-cache is granted ahead of the D-cache

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (rst=0 resets on posedge clk)
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line data to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback data
- d_rdata  out  LINE_W  line data to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  line read to memory, held until pmem_resp
- pmem_write  out  1  line write to memory, held until pmem_resp
- pmem_addr  out  ADDR_W  registered address of granted request
- pmem_wdata  out  LINE_W  registered write data
- pmem_rdata  in  LINE_W  returned line
- pmem_resp  in  1  one-cycle completion pulse from memory

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE.
- Reset: state=IDLE, starve_cnt=0. All outputs 0: pmem_read, pmem_write, pmem_addr, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- IDLE, grant decision:
  - d_req = d_read|d_write.
  - If d_req and (!i_read or starve_cnt<STARVE_MAX): go to BUSY_D. Latch d_addr and d_wdata. pmem_read<=d_read, pmem_write<=d_write.
  - Else if i_read: go to BUSY_I. Latch i_addr. pmem_read<=1.
  - Else stay in IDLE.
- Latency: request sampled at edge N; pmem_* valid from cycle N+1 (registered).
- starve_cnt:
  - Increments (saturating at STARVE_MAX) at each IDLE grant to D while i_read=1.
  - Clears on any I grant.
- d_read and d_write both asserted: protocol error. Treat as write (pmem_write=1, pmem_read=0).
- BUSY_x: pmem_* held stable. Request-input changes are ignored.
- On pmem_resp=1 in cycle M:
  - The granted cache's resp is driven combinationally in cycle M and its rdata = pmem_rdata.
  - pmem_read and pmem_write <= 0.
  - Go to DONE.
  - The non-granted resp stays 0.
- DONE: one cycle, always returns to IDLE. Requests are ignored, which absorbs stale request levels. Earliest next grant is at the edge ending cycle M+2.
- pmem_resp outside BUSY_x: ignored, no resp generated.
- i_rdata and d_rdata: driven with pmem_rdata only while the matching resp is high, else 0.
- Reset mid-transaction: abort, return to IDLE, drop pmem_* to 0 that edge. Late pmem_resp is ignored per the rule above.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined: adds outputs perf_i_grants[31:0], perf_d_grants[31:0], perf_i_wait[31:0].
  - perf_i_grants and perf_d_grants increment on each respective grant.
  - perf_i_wait increments each cycle i_read=1 and state≠BUSY_I.
  - All three wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent. Arbitration is identical.

Decomposition:
- Package arb_types:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, DONE}
  - grant_t enum {GNT_NONE, GNT_I, GNT_D}
  - localparam default STARVE_MAX
- One sub-module is natural: arb_starve_ctr, a saturating counter with inc/clr/sat outputs, instantiated once.

Test Plan:
- Reset: hold rst=0 3 cycles with i_read=1 → all outputs 0, state IDLE; release → pmem_read=1, pmem_addr=i_addr one cycle later.
- Single I read, addr 0x0000_1000, memory resp after 5 cycles → i_resp pulses 1 cycle with i_rdata=pmem_rdata; d_resp stays 0; next grant no earlier than M+2.
- Simultaneous i_read and d_write (addr 0x8000_0040, wdata pattern A5…) → D granted first with pmem_write=1 and correct wdata; I granted after DONE.
- D-cache asserting requests continuously, I waiting → I granted after exactly 8 D grants; starve_cnt clears.
- Reset asserted in BUSY_D, then pmem_resp arrives → no d_resp; arbiter IDLE; pmem_write=0.
- ARB_PERF_EN: 3 I and 2 D transactions → perf_i_grants=3, perf_d_grants=2, perf_i_wait equals counted stall cycles.

Source files
------------

// File: rtl/arb_types.sv
// Shared types and defaults for the I/D cache line-port arbiter.
package arb_types;

    localparam int unsigned LINE_W_DEF     = 256;
    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of arbitrations the I-cache lost to the D-cache.
module arb_starve_ctr #(
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_W'(MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/cache_arbiter.sv
// Shares the physical-memory line port between I-cache and D-cache.
// Optional performance counters are enabled with macro ARB_PERF_EN.
module cache_arbiter
    import arb_types::*;
#(
    parameter int unsigned LINE_W     = LINE_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_i_wait
`endif
);

    arb_state_t        state_q, state_d;
    grant_t            grant;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic              d_req;
    logic              resp_ok;
    logic              starve_sat;

    assign d_req   = d_read | d_write;
    // A response arriving while reset is asserted belongs to an aborted transfer.
    assign resp_ok = pmem_resp & rst;

    always_comb begin
        state_d      = state_q;
        grant        = GNT_NONE;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_read || !starve_sat)) begin
                    grant        = GNT_D;
                    state_d      = BUSY_D;
                    pmem_addr_d  = d_addr;
                    pmem_wdata_d = d_wdata;
                    // Read+write together is treated as a writeback.
                    pmem_write_d = d_write;
                    pmem_read_d  = d_read & ~d_write;
                end else if (i_read) begin
                    grant        = GNT_I;
                    state_d      = BUSY_I;
                    pmem_addr_d  = i_addr;
                    pmem_wdata_d = '0;
                    pmem_read_d  = 1'b1;
                    pmem_write_d = 1'b0;
                end
            end
            BUSY_I: begin
                if (resp_ok) begin
                    i_resp       = 1'b1;
                    i_rdata      = pmem_rdata;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE;
                end
            end
            BUSY_D: begin
                if (resp_ok) begin
                    d_resp       = 1'b1;
                    d_rdata      = pmem_rdata;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
        end
    end

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;

    arb_starve_ctr #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc_i((grant == GNT_D) && i_read),
        .clr_i(grant == GNT_I),
        .sat_o(starve_sat)
    );

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_i_grants <= '0;
            perf_d_grants <= '0;
            perf_i_wait   <= '0;
        end else begin
            if (grant == GNT_I) perf_i_grants <= perf_i_grants + 32'd1;
            if (grant == GNT_D) perf_d_grants <= perf_d_grants + 32'd1;
            if (i_read && (state_q != BUSY_I)) perf_i_wait <= perf_i_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed scoreboard bench for cache_arbiter (perf checks with ARB_PERF_EN).
module tb_cache_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
`ifdef ARB_PERF_EN
    logic [31:0]   perf_i_grants;
    logic [31:0]   perf_d_grants;
    logic [31:0]   perf_i_wait;
`endif

    cache_arbiter dut (
`ifdef ARB_PERF_EN
        .perf_i_grants(perf_i_grants),
        .perf_d_grants(perf_d_grants),
        .perf_i_wait  (perf_i_wait),
`endif
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr (pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp (pmem_resp)
    );

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   lat;
    logic busy_i;
    int   m_i_gr;
    int   m_d_gr;
    int   m_i_wait;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference count of cycles the I-cache spends requesting without being served.
    always @(posedge clk) begin
        if (!rst) m_i_wait = 0;
        else if (i_read && !busy_i) m_i_wait = m_i_wait + 1;
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] w);
        exp_t e;
        e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = w;
        q.push_back(e);
    endtask

    // Waits for the next memory transaction, checks it against the scoreboard,
    // answers after mlat cycles and checks the response routing.
    task automatic serve(input int mlat, output int n);
        exp_t          e;
        logic [LW-1:0] rd;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 100) begin
            step();
            n++;
        end
        chk("grant_timeout", LW'(n < 100), LW'(1));
        if (n >= 100) return;
        if (q.size() == 0) begin
            chk("sb_unexpected_txn", LW'(0), LW'(1));
            return;
        end
        e = q.pop_front();
        if (e.is_d) m_d_gr++;
        else begin
            m_i_gr++;
            busy_i = 1'b1;
        end
        chk("pmem_read", LW'(pmem_read), LW'(!e.wr));
        chk("pmem_write", LW'(pmem_write), LW'(e.wr));
        chk("pmem_addr", LW'(pmem_addr), LW'(e.addr));
        if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
        repeat (mlat) begin
            step();
            chk("hold_addr", LW'(pmem_addr), LW'(e.addr));
        end
        rd = rnd_line();
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        chk("i_resp", LW'(i_resp), LW'(!e.is_d));
        chk("d_resp", LW'(d_resp), LW'(e.is_d));
        chk("i_rdata", i_rdata, e.is_d ? '0 : rd);
        chk("d_rdata", d_rdata, e.is_d ? rd : '0);
        step();
        busy_i     = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        chk("done_resp", LW'({i_resp, d_resp}), LW'(0));
        chk("done_pmem", LW'({pmem_read, pmem_write}), LW'(0));
    endtask

    initial begin
        logic [LW-1:0] w;
        total = 0; bad = 0; busy_i = 1'b0;
        m_i_gr = 0; m_d_gr = 0; m_i_wait = 0;
        rst = 1'b0; i_read = 1'b1; i_addr = 32'h0000_0100;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // Reset held with a pending I request: everything quiet.
        repeat (3) begin
            step();
            chk("rst_pmem", LW'({pmem_read, pmem_write}), LW'(0));
            chk("rst_addr", LW'(pmem_addr), LW'(0));
            chk("rst_wdata", pmem_wdata, '0);
            chk("rst_resp", LW'({i_resp, d_resp}), LW'(0));
            chk("rst_rdata", i_rdata | d_rdata, '0);
        end
        rst = 1'b1;
        push(1'b0, 1'b0, 32'h0000_0100, '0);
        serve(2, lat);
        chk("rst_release_lat", LW'(lat), LW'(1));
        i_read = 1'b0;
        step(); step();

        // Single I read with 5-cycle memory; stale request must not regrant before M+3.
        i_read = 1'b1; i_addr = 32'h0000_1000;
        push(1'b0, 1'b0, 32'h0000_1000, '0);
        serve(5, lat);
        chk("i_grant_lat", LW'(lat), LW'(1));
        push(1'b0, 1'b0, 32'h0000_1000, '0);
        step();
        chk("no_early_grant", LW'(pmem_read), LW'(0));
        serve(1, lat);
        chk("regrant_lat", LW'(lat), LW'(1));
        i_read = 1'b0;
        step(); step();

        // Simultaneous I read and D write: D first.
        w = {32{8'hA5}};
        i_read = 1'b1; i_addr = 32'h0000_2000;
        d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = w;
        push(1'b1, 1'b1, 32'h8000_0040, w);
        push(1'b0, 1'b0, 32'h0000_2000, '0);
        serve(3, lat);
        d_write = 1'b0;
        serve(2, lat);
        i_read = 1'b0;
        step(); step();

        // Continuous D traffic starves I for exactly STARVE_MAX grants.
        i_read = 1'b1; i_addr = 32'h0000_3000;
        d_write = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d_addr = 32'h0000_4000 + 32'(k * 64);
            d_wdata = rnd_line();
            push(1'b1, 1'b1, d_addr, d_wdata);
            serve(1, lat);
        end
        d_addr = 32'h0000_5000; d_wdata = rnd_line();
        push(1'b0, 1'b0, 32'h0000_3000, '0);
        serve(1, lat);
        push(1'b1, 1'b1, 32'h0000_5000, d_wdata);
        serve(1, lat);
        i_read = 1'b0; d_write = 1'b0;
        step(); step();

        // Read+write together is a writeback; then a plain D read.
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_6000; d_wdata = rnd_line();
        push(1'b1, 1'b1, 32'h0000_6000, d_wdata);
        serve(2, lat);
        d_write = 1'b0; d_addr = 32'h0000_6040;
        push(1'b1, 1'b0, 32'h0000_6040, '0);
        serve(2, lat);
        d_read = 1'b0;
        step(); step();

        // Stray memory response while idle.
        pmem_resp = 1'b1; pmem_rdata = rnd_line();
        #1;
        chk("idle_resp", LW'({i_resp, d_resp}), LW'(0));
        chk("idle_rdata", i_rdata | d_rdata, '0);
        step();
        pmem_resp = 1'b0; pmem_rdata = '0;
        chk("idle_no_grant", LW'({pmem_read, pmem_write}), LW'(0));

        // Reset in BUSY_D, then a late response.
        d_write = 1'b1; d_addr = 32'h0000_7000; d_wdata = rnd_line();
        step();
        chk("busy_d_write", LW'(pmem_write), LW'(1));
        rst = 1'b0;
        step();
        chk("abort_write", LW'(pmem_write), LW'(0));
        chk("abort_addr", LW'(pmem_addr), LW'(0));
        rst = 1'b1; d_write = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = rnd_line();
        #1;
        chk("late_d_resp", LW'({i_resp, d_resp}), LW'(0));
        chk("late_rdata", d_rdata, '0);
        step();
        pmem_resp = 1'b0; pmem_rdata = '0;
        chk("late_pmem", LW'({pmem_read, pmem_write}), LW'(0));

        // Fresh reset, then 3 I and 2 D transactions for the perf counters.
        rst = 1'b0;
        step();
        rst = 1'b1; m_i_gr = 0; m_d_gr = 0;
        i_read = 1'b1; i_addr = 32'h0000_8000;
        d_read = 1'b1; d_addr = 32'h0000_9000;
        push(1'b1, 1'b0, 32'h0000_9000, '0);
        push(1'b0, 1'b0, 32'h0000_8000, '0);
        serve(2, lat);
        d_read = 1'b0;
        serve(3, lat);
        i_read = 1'b0;
        d_write = 1'b1; d_addr = 32'h0000_9040; d_wdata = rnd_line();
        push(1'b1, 1'b1, 32'h0000_9040, d_wdata);
        serve(1, lat);
        d_write = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_read = 1'b1; i_addr = 32'h0000_A000 + 32'(k * 64);
            push(1'b0, 1'b0, i_addr, '0);
            serve(2, lat);
            i_read = 1'b0;
            step();
        end
        step();
        chk("sb_drained", LW'(q.size()), LW'(0));
`ifdef ARB_PERF_EN
        chk("perf_i_grants", LW'(perf_i_grants), LW'(m_i_gr));
        chk("perf_d_grants", LW'(perf_d_grants), LW'(m_d_gr));
        chk("perf_i_wait", LW'(perf_i_wait), LW'(m_i_wait));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
